// File: rtl/cpu_out_console.sv
// CPU byte-output console: FIFO-buffered bytes rendered as decimal ASCII lines.
// Emits one character per valid/ready transfer; sticky flag records dropped bytes.
module cpu_out_console #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              data_in_new,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUND,
    S_TENS,
    S_ONES,
    S_NL
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;

  state_t            state_q, state_d;
  logic [7:0]        val_q, val_d;
  logic [7:0]        tens_q, tens_d;
  logic [7:0]        ones_q, ones_d;
  logic [7:0]        char_q, char_d;
  logic              valid_q, valid_d;

  logic [7:0]        head;
  logic [7:0]        hund_c;
  logic [7:0]        rem_c;
  logic [7:0]        tens_c;
  logic [7:0]        ones_c;
  logic              pop;
  logic              push;

  assign head = mem_q[rptr_q];
  assign pop  = (state_q == S_IDLE) && (level_q != '0);
  assign push = data_in_new && ((level_q != FULL) || pop);

  // Split the head byte into decimal digits so the first character
  // can be registered on the same edge that pops it.
  always_comb begin
    hund_c = 8'd0;
    rem_c  = head;
    if (head >= 8'd200) begin
      hund_c = 8'd2;
      rem_c  = head - 8'd200;
    end else if (head >= 8'd100) begin
      hund_c = 8'd1;
      rem_c  = head - 8'd100;
    end
    tens_c = rem_c / 8'd10;
    ones_c = rem_c % 8'd10;
  end

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + ADDR_W'(1);
    if (pop)  rptr_d = rptr_q + ADDR_W'(1);
    if (push && !pop)
      level_d = level_q + (ADDR_W+1)'(1);
    else if (pop && !push)
      level_d = level_q - (ADDR_W+1)'(1);
    if (data_in_new && !push) ovf_d = 1'b1;
  end

  // Emitter FSM: pick the first significant digit, then walk down to NL.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    char_d  = char_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (pop) begin
          val_d   = head;
          tens_d  = tens_c;
          ones_d  = ones_c;
          valid_d = 1'b1;
          if (hund_c != 8'd0) begin
            state_d = S_HUND;
            char_d  = ASCII_0 + hund_c;
          end else if (tens_c != 8'd0) begin
            state_d = S_TENS;
            char_d  = ASCII_0 + tens_c;
          end else begin
            state_d = S_ONES;
            char_d  = ASCII_0 + ones_c;
          end
        end
      end
      S_HUND: begin
        if (char_ready) begin
          state_d = S_TENS;
          char_d  = ASCII_0 + tens_q;
        end
      end
      S_TENS: begin
        if (char_ready) begin
          state_d = S_ONES;
          char_d  = ASCII_0 + ones_q;
        end
      end
      S_ONES: begin
        if (char_ready) begin
          state_d = S_NL;
          char_d  = ASCII_NL;
        end
      end
      S_NL: begin
        if (char_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data_in;
  end

  // State register for FIFO bookkeeping and emitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      val_q   <= 8'd0;
      tens_q  <= 8'd0;
      ones_q  <= 8'd0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      val_q   <= val_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule
